sine_voice_scheduler: RTL and testbench
=======================================

Name: sine_voice_scheduler

Overview:
- Time-multiplexes one shared pipelined quarter-wave sine unit among NVOICES polyphonic voices.
- Holds one phase accumulator and increment per voice, and handles note-on/off voice allocation.
- Once per audio sample tick, issues every voice's phase into the sine pipeline, accumulates the returned samples, and emits one saturated mixed sample.
- Sits between the MIDI/note decoder upstream and the sine pipeline plus DAC/output path downstream.

Parameters:
- NVOICES, 8, number of voices (≥2, power of two).
- PIPE_LAT, 3, sine pipeline latency in clk_en cycles from o_phase/o_valid to i_sine/i_sine_valid.
- SHIFT, 3, arithmetic right shift applied to the voice sum before saturation.

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-high
- clk_en  in  1  global enable; all state advances only when high
- i_tick  in  1  sample-rate strobe, one clk_en cycle wide
- i_cmd_valid  in  1  note command strobe
- i_cmd_on  in  1  1 = note-on, 0 = note-off
- i_cmd_midi  in  7  note number
- i_cmd_inc  in  16  phase increment for note-on
- o_cmd_ready  out  1  command accepted this cycle when high
- o_cmd_drop  out  1  one-cycle pulse: note-on with no free voice
- o_phase  out  16  phase to sine unit
- o_midi  out  7  midi tag to sine unit
- o_valid  out  1  issue strobe to sine unit
- i_sine  in  24  signed sample from sine unit
- i_sine_valid  in  1  sample valid from sine unit
- o_sample  out  24  signed mixed sample
- o_sample_valid  out  1  one-cycle pulse
- o_overrun  out  1  one-cycle pulse: i_tick arrived while not IDLE
- o_active  out  NVOICES  active-voice bitmap

Behaviour:
- Reset: every output is 0; all phases, increments, active bits and midi tags are 0; accumulator is 0; FSM is IDLE.
- All register updates are gated by clk_en. Cycle counts below are clk_en cycles.
- FSM states:
  - IDLE: o_cmd_ready=1. i_tick → ISSUE, with voice index=0 and accumulator cleared.
  - ISSUE: one voice per cycle. Registered outputs: o_phase=phase[v], o_midi=tag[v], o_valid=active[v]. Then phase[v] <= phase[v]+inc[v] (mod 2^16) if active. After v=NVOICES-1 → DRAIN.
  - DRAIN: PIPE_LAT cycles; the counter loads on ISSUE exit. Then → MIX.
  - MIX: o_sample = sat24(acc >>> SHIFT); o_sample_valid=1 for one cycle → IDLE.
- Latency: tick sampled at cycle T; voice k is visible on o_phase at T+1+k; o_sample_valid is visible at T+NVOICES+PIPE_LAT+1.
- Accumulator:
  - Signed, 24+log2(NVOICES) bits.
  - Adds i_sine whenever i_sine_valid=1 in ISSUE or DRAIN; invalid returns add nothing.
  - Saturation clamps to 0x7FFFFF / 0x800000.
- Commands: processed only in IDLE; o_cmd_ready is registered as (state==IDLE).
  - Note-on, midi already active in voice v: inc[v] <= i_cmd_inc, phase[v] <= 0.
  - Note-on, otherwise: allocate the lowest-index free voice (tag, inc, phase=0, active=1). If no voice is free, nothing changes and o_cmd_drop pulses.
  - Note-off: clear active on the matching voice. No match → ignored.
- i_tick in any non-IDLE state: tick is ignored; o_overrun pulses; the current frame completes normally.
- i_tick and i_cmd_valid in the same IDLE cycle: the command is applied first, and the new voice participates in this frame.
- clk_en low: FSM, counters and outputs hold. o_valid and o_sample_valid are not re-asserted.
- rst mid-frame: immediate return to the reset state. In-flight sine results are discarded because the accumulator is cleared on the next tick.

Decomposition:
- Shared package synth_pkg: PHASE_W=16, SAMPLE_W=24, MIDI_W=7, and the FSM state encoding (IDLE/ISSUE/DRAIN/MIX).
- One natural sub-module, voice_alloc: combinational priority encoder returning a free-voice index, a midi-match index and their hit flags.

Test Plan:
1. Reset, then tick with no voices active → o_valid never high; o_sample=0, o_sample_valid at tick+12 (NVOICES=8, PIPE_LAT=3); o_active=0.
2. Note-on midi 69, inc 0x4000, then 4 ticks → issued phases 0x0000, 0x4000, 0x8000, 0xC000; samples are 0, +P>>3, 0, −P>>3 (P = LUT peak).
3. 9 note-ons with distinct midi → voices 0..7 allocated, o_active=0xFF, 9th pulses o_cmd_drop with state unchanged. Then note-off midi of voice 3 and a new note-on → voice 3 reused.
4. 8 voices at inc 0, all phases forced to 0x4000 via retrigger sequence, SHIFT=0 → sum 8·P exceeds range → o_sample=0x7FFFFF.
5. Second i_tick 3 cycles after the first → o_overrun pulses once; exactly one o_sample_valid per frame.
6. clk_en toggling 1-of-2 during a frame → identical o_sample values, latency doubled in clk cycles. rst asserted during DRAIN → all outputs 0, next frame correct.

Source files
------------

// File: rtl/sine_voice_scheduler_pkg.sv
// Shared widths, FSM encoding and the output saturation helper for the
// polyphonic sine voice scheduler.
package synth_pkg;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 24;
  localparam int MIDI_W   = 7;

  // Frame sequencer states: wait for a tick, issue every voice, wait for the
  // sine pipeline to empty, then publish the mixed sample.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_MIX
  } state_t;

  // Clamp a sign-extended mix value into the signed 24-bit output range.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [47:0] v);
    if (v > 48'sh7F_FFFF) begin
      return 24'h7F_FFFF;
    end else if (v < -48'sh80_0000) begin
      return 24'h80_0000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sine_voice_scheduler_if.sv
// Bundle of the note-command, sine-unit and mixed-output signals of the
// scheduler. The slave side is the scheduler; the master side is everything
// around it (note decoder, sine pipeline, output path).
interface sine_voice_scheduler_if
  import synth_pkg::*;
#(
  parameter int NVOICES = 8
);

  logic                clk_en;
  logic                i_tick;
  logic                i_cmd_valid;
  logic                i_cmd_on;
  logic [MIDI_W-1:0]   i_cmd_midi;
  logic [PHASE_W-1:0]  i_cmd_inc;
  logic                o_cmd_ready;
  logic                o_cmd_drop;
  logic [PHASE_W-1:0]  o_phase;
  logic [MIDI_W-1:0]   o_midi;
  logic                o_valid;
  logic [SAMPLE_W-1:0] i_sine;
  logic                i_sine_valid;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_sample_valid;
  logic                o_overrun;
  logic [NVOICES-1:0]  o_active;

  modport master (
    output clk_en, i_tick, i_cmd_valid, i_cmd_on, i_cmd_midi, i_cmd_inc,
           i_sine, i_sine_valid,
    input  o_cmd_ready, o_cmd_drop, o_phase, o_midi, o_valid,
           o_sample, o_sample_valid, o_overrun, o_active
  );

  modport slave (
    input  clk_en, i_tick, i_cmd_valid, i_cmd_on, i_cmd_midi, i_cmd_inc,
           i_sine, i_sine_valid,
    output o_cmd_ready, o_cmd_drop, o_phase, o_midi, o_valid,
           o_sample, o_sample_valid, o_overrun, o_active
  );

endinterface

// File: rtl/sine_voice_scheduler_voice_alloc.sv
// Voice allocation helper: finds the lowest-index free voice and the
// lowest-index active voice already playing a given note.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NVOICES = 8
) (
  input  logic [NVOICES-1:0]              active,
  input  logic [NVOICES-1:0][MIDI_W-1:0]  tags,
  input  logic [MIDI_W-1:0]               midi,
  output logic [$clog2(NVOICES)-1:0]      free_idx,
  output logic                            free_hit,
  output logic [$clog2(NVOICES)-1:0]      match_idx,
  output logic                            match_hit
);

  localparam int IDX_W = $clog2(NVOICES);

  // Priority encode from the top down so the lowest matching index wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    free_idx  = '0;
    free_hit  = 1'b0;
    match_idx = '0;
    match_hit = 1'b0;
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
      if (active[i] && (tags[i] == midi)) begin
        match_hit = 1'b1;
        match_idx = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one pipelined sine unit among NVOICES voices. Each sample
// tick walks every voice through the sine unit, sums the returned samples,
// and emits one shifted, saturated mix. Note commands are taken between
// frames only.
module sine_voice_scheduler
  import synth_pkg::*;
#(
  parameter int NVOICES  = 8,
  parameter int PIPE_LAT = 3,
  parameter int SHIFT    = 3
) (
  input logic                   clk,
  input logic                   rst,
  sine_voice_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NVOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_t                           state;
  logic [IDX_W-1:0]                 vidx;
  logic [CNT_W-1:0]                 drain_cnt;
  logic signed [ACC_W-1:0]          acc;

  logic [NVOICES-1:0][PHASE_W-1:0]  phase;
  logic [NVOICES-1:0][PHASE_W-1:0]  inc;
  logic [NVOICES-1:0][MIDI_W-1:0]   tag;
  logic [NVOICES-1:0]               active;

  logic                             cmd_ready;
  logic                             cmd_drop;
  logic [PHASE_W-1:0]               out_phase;
  logic [MIDI_W-1:0]                out_midi;
  logic                             out_valid;
  logic [SAMPLE_W-1:0]              out_sample;
  logic                             out_sample_valid;
  logic                             overrun;

  logic [IDX_W-1:0]                 free_idx;
  logic                             free_hit;
  logic [IDX_W-1:0]                 match_idx;
  logic                             match_hit;

  logic signed [ACC_W-1:0]          sine_ext;

  voice_alloc #(
    .NVOICES (NVOICES)
  ) u_voice_alloc (
    .active    (active),
    .tags      (tag),
    .midi      (bus.i_cmd_midi),
    .free_idx  (free_idx),
    .free_hit  (free_hit),
    .match_idx (match_idx),
    .match_hit (match_hit)
  );

  // Returned samples are signed; widen with sign extension, and contribute
  // nothing when the sine unit flags the slot as empty.
  assign sine_ext = bus.i_sine_valid
                  ? {{IDX_W{bus.i_sine[SAMPLE_W-1]}}, bus.i_sine}
                  : '0;

  // Frame sequencer, voice table and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      vidx             <= '0;
      drain_cnt        <= '0;
      acc              <= '0;
      // NOTE: the voice table is reset too: a stale active bit or tag after
      // reset would produce sound or match note-offs that nobody sent.
      phase            <= '0;
      inc              <= '0;
      tag              <= '0;
      active           <= '0;
      cmd_ready        <= 1'b0;
      cmd_drop         <= 1'b0;
      out_phase        <= '0;
      out_midi         <= '0;
      out_valid        <= 1'b0;
      out_sample       <= '0;
      out_sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else if (bus.clk_en) begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the pre-edge value regardless of statement order.
      cmd_drop         <= 1'b0;
      out_valid        <= 1'b0;
      out_sample_valid <= 1'b0;
      overrun          <= bus.i_tick && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (bus.i_cmd_valid) begin
            if (bus.i_cmd_on) begin
              if (match_hit) begin
                inc[match_idx]   <= bus.i_cmd_inc;
                phase[match_idx] <= '0;
              end else if (free_hit) begin
                tag[free_idx]    <= bus.i_cmd_midi;
                inc[free_idx]    <= bus.i_cmd_inc;
                phase[free_idx]  <= '0;
                active[free_idx] <= 1'b1;
              end else begin
                cmd_drop <= 1'b1;
              end
            end else if (match_hit) begin
              active[match_idx] <= 1'b0;
            end
          end
          // A command in the tick cycle lands in the table this edge, so the
          // first ISSUE cycle already sees it.
          if (bus.i_tick) begin
            state     <= ST_ISSUE;
            vidx      <= '0;
            acc       <= '0;
            cmd_ready <= 1'b0;
          end
        end

        ST_ISSUE: begin
          out_phase <= phase[vidx];
          out_midi  <= tag[vidx];
          out_valid <= active[vidx];
          if (active[vidx]) begin
            phase[vidx] <= phase[vidx] + inc[vidx];
          end
          acc  <= acc + sine_ext;
          vidx <= vidx + 1'b1;
          if (vidx == IDX_W'(NVOICES - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(PIPE_LAT - 1);
          end
        end

        ST_DRAIN: begin
          acc <= acc + sine_ext;
          if (drain_cnt == '0) begin
            state <= ST_MIX;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        ST_MIX: begin
          out_sample       <= sat_sample(48'(acc >>> SHIFT));
          out_sample_valid <= 1'b1;
          cmd_ready        <= 1'b1;
          state            <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready    = cmd_ready;
  assign bus.o_cmd_drop     = cmd_drop;
  assign bus.o_phase        = out_phase;
  assign bus.o_midi         = out_midi;
  assign bus.o_valid        = out_valid;
  assign bus.o_sample       = out_sample;
  assign bus.o_sample_valid = out_sample_valid;
  assign bus.o_overrun      = overrun;
  assign bus.o_active       = active;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed bench for sine_voice_scheduler. Two instances run in lockstep on
// identical inputs: one with the default SHIFT=3, one with SHIFT=0 so the
// mix saturates. A small registered sine model returns a quarter-wave value
// PIPE_LAT enabled cycles after each issue.
module tb_sine_voice_scheduler;

  localparam int NVOICES  = 8;
  localparam int PIPE_LAT = 3;
  localparam logic [23:0] PEAK     = 24'h7F_FFFF;
  localparam logic [23:0] NEG_PEAK = 24'h80_0001;
  localparam logic [23:0] JUNK     = 24'h12_3456;

  logic clk = 1'b0;
  logic rst;
  bit   half_rate = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int          n_issue;
  int          n_svalid;
  int          n_over;
  logic [15:0] iss_phase [16];
  logic [6:0]  iss_midi  [16];

  sine_voice_scheduler_if #(.NVOICES(NVOICES)) bus_a ();
  sine_voice_scheduler_if #(.NVOICES(NVOICES)) bus_b ();

  sine_voice_scheduler #(
    .NVOICES (NVOICES),
    .PIPE_LAT(PIPE_LAT),
    .SHIFT   (3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  sine_voice_scheduler #(
    .NVOICES (NVOICES),
    .PIPE_LAT(PIPE_LAT),
    .SHIFT   (0)
  ) u_dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Clock enable: steady high, or alternating when half_rate is set.
  always @(negedge clk) begin
    #1;
    if (half_rate) bus_a.clk_en = ~bus_a.clk_en;
    else           bus_a.clk_en = 1'b1;
  end

  assign bus_b.clk_en      = bus_a.clk_en;
  assign bus_b.i_tick      = bus_a.i_tick;
  assign bus_b.i_cmd_valid = bus_a.i_cmd_valid;
  assign bus_b.i_cmd_on    = bus_a.i_cmd_on;
  assign bus_b.i_cmd_midi  = bus_a.i_cmd_midi;
  assign bus_b.i_cmd_inc   = bus_a.i_cmd_inc;

  function automatic logic [23:0] sine_of(input logic [15:0] ph);
    case (ph)
      16'h4000: return PEAK;
      16'hC000: return NEG_PEAK;
      default:  return 24'h0;
    endcase
  endfunction

  // Sine unit models: PIPE_LAT-1 registers, so the DUT captures a result on
  // the PIPE_LAT-th enabled edge after the issue became visible.
  logic [1:0]  pv_a = '0;
  logic [23:0] pd_a [2] = '{24'h0, 24'h0};
  logic [1:0]  pv_b = '0;
  logic [23:0] pd_b [2] = '{24'h0, 24'h0};

  always @(posedge clk) begin
    if (bus_a.clk_en) begin
      pv_a    <= {pv_a[0], bus_a.o_valid};
      pd_a[1] <= pd_a[0];
      pd_a[0] <= sine_of(bus_a.o_phase);
      pv_b    <= {pv_b[0], bus_b.o_valid};
      pd_b[1] <= pd_b[0];
      pd_b[0] <= sine_of(bus_b.o_phase);
    end
  end

  assign bus_a.i_sine_valid = pv_a[1];
  assign bus_a.i_sine       = pv_a[1] ? pd_a[1] : JUNK;
  assign bus_b.i_sine_valid = pv_b[1];
  assign bus_b.i_sine       = pv_b[1] ? pd_b[1] : JUNK;

  // Record what the downstream side actually accepts on enabled edges.
  always @(posedge clk) begin
    if (!rst && bus_a.clk_en) begin
      if (bus_a.o_valid && n_issue < 16) begin
        iss_phase[n_issue] = bus_a.o_phase;
        iss_midi[n_issue]  = bus_a.o_midi;
        n_issue++;
      end
      if (bus_a.o_sample_valid) n_svalid++;
      if (bus_a.o_overrun)      n_over++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input bit on, input logic [6:0] midi, input logic [15:0] inc,
                          output logic drop);
    @(negedge clk); #2;
    bus_a.i_cmd_valid = 1'b1;
    bus_a.i_cmd_on    = on;
    bus_a.i_cmd_midi  = midi;
    bus_a.i_cmd_inc   = inc;
    @(posedge clk);
    @(negedge clk); #2;
    bus_a.i_cmd_valid = 1'b0;
    drop = bus_a.o_cmd_drop;
  endtask

  // One frame: tick (optionally with a command in the same cycle, or with a
  // second tick three cycles later), then wait for the mixed sample.
  task automatic run_frame(input bit dbl, input bit with_cmd, input bit c_on,
                           input logic [6:0] c_midi, input logic [15:0] c_inc,
                           output int lat, output logic [23:0] sa, output logic [23:0] sb);
    bit done;
    n_issue  = 0;
    n_svalid = 0;
    n_over   = 0;
    sa = 'x;
    sb = 'x;
    @(negedge clk); #2;
    while (!bus_a.clk_en) begin
      @(negedge clk); #2;
    end
    bus_a.i_tick = 1'b1;
    if (with_cmd) begin
      bus_a.i_cmd_valid = 1'b1;
      bus_a.i_cmd_on    = c_on;
      bus_a.i_cmd_midi  = c_midi;
      bus_a.i_cmd_inc   = c_inc;
    end
    @(posedge clk);
    @(negedge clk); #2;
    bus_a.i_tick      = 1'b0;
    bus_a.i_cmd_valid = 1'b0;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk); #2;
      if (dbl) bus_a.i_tick = (lat == 2);
      if (bus_a.o_sample_valid) begin
        done = 1'b1;
        sa   = bus_a.o_sample;
        sb   = bus_b.o_sample;
      end
    end
    bus_a.i_tick = 1'b0;
    if (!done) check("frame_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int          lat;
    logic [23:0] sa;
    logic [23:0] sb;
    logic        drop;
    logic [23:0] exp_a [4];
    logic [23:0] exp_b [4];

    rst               = 1'b1;
    bus_a.i_tick      = 1'b0;
    bus_a.i_cmd_valid = 1'b0;
    bus_a.i_cmd_on    = 1'b0;
    bus_a.i_cmd_midi  = '0;
    bus_a.i_cmd_inc   = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_sample",       32'(bus_a.o_sample),       32'h0);
    check("rst_sample_valid", 32'(bus_a.o_sample_valid), 32'h0);
    check("rst_valid",        32'(bus_a.o_valid),        32'h0);
    check("rst_cmd_ready",    32'(bus_a.o_cmd_ready),    32'h0);
    check("rst_active",       32'(bus_a.o_active),       32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("idle_cmd_ready", 32'(bus_a.o_cmd_ready), 32'h1);

    // Empty frame: nothing issued, zero mix, 12-cycle latency.
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("empty_latency", 32'(lat),     32'd12);
    check("empty_sample",  32'(sa),      32'h0);
    check("empty_issues",  32'(n_issue), 32'd0);

    // Single voice stepping through the four quarter points.
    send_cmd(1'b1, 7'd69, 16'h4000, drop);
    check("on69_drop",   32'(drop),           32'h0);
    check("on69_active", 32'(bus_a.o_active), 32'h01);
    exp_a = '{24'h0, 24'h0F_FFFF, 24'h0, 24'hF0_0000};
    exp_b = '{24'h0, 24'h7F_FFFF, 24'h0, 24'h80_0001};
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
      check($sformatf("v0_issues_%0d", f), 32'(n_issue),      32'd1);
      check($sformatf("v0_phase_%0d", f),  32'(iss_phase[0]), 32'(16'h4000 * f));
      check($sformatf("v0_midi_%0d", f),   32'(iss_midi[0]),  32'd69);
      check($sformatf("v0_sample_%0d", f), 32'(sa),           32'(exp_a[f]));
      check($sformatf("v0_sat0_%0d", f),   32'(sb),           32'(exp_b[f]));
    end

    // Fill all voices, then one note-on too many.
    for (int m = 0; m < 7; m++) begin
      send_cmd(1'b1, 7'(60 + m), 16'h4000, drop);
    end
    check("full_active", 32'(bus_a.o_active), 32'hFF);
    send_cmd(1'b1, 7'd70, 16'h1234, drop);
    check("full_drop",        32'(drop),           32'h1);
    check("full_active_keep", 32'(bus_a.o_active), 32'hFF);
    @(negedge clk); #2;
    check("drop_one_cycle", 32'(bus_a.o_cmd_drop), 32'h0);

    // All eight voices in phase: +8P and -8P mixes, saturating with SHIFT=0.
    exp_a = '{24'h0, 24'h7F_FFFF, 24'h0, 24'h80_0001};
    exp_b = '{24'h0, 24'h7F_FFFF, 24'h0, 24'h80_0000};
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
      check($sformatf("all_issues_%0d", f), 32'(n_issue), 32'd8);
      check($sformatf("all_sample_%0d", f), 32'(sa),      32'(exp_a[f]));
      check($sformatf("all_sat0_%0d", f),   32'(sb),      32'(exp_b[f]));
    end

    // Free voice 3, ignore an unknown note-off, reuse voice 3.
    send_cmd(1'b0, 7'd62, 16'h0, drop);
    check("off62_active", 32'(bus_a.o_active), 32'hF7);
    send_cmd(1'b0, 7'd100, 16'h0, drop);
    check("off100_active", 32'(bus_a.o_active), 32'hF7);
    send_cmd(1'b1, 7'd80, 16'h0000, drop);
    check("reuse_drop",   32'(drop),           32'h0);
    check("reuse_active", 32'(bus_a.o_active), 32'hFF);
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("reuse_midi3",  32'(iss_midi[3]),  32'd80);
    check("reuse_phase3", 32'(iss_phase[3]), 32'h0);
    check("reuse_sample", 32'(sa),           32'h0);

    // Note-off in the tick cycle: voice 3 already silent for this frame.
    run_frame(1'b0, 1'b1, 1'b0, 7'd80, 16'h0, lat, sa, sb);
    check("tickcmd_issues", 32'(n_issue), 32'd7);
    check("tickcmd_sample", 32'(sa),      32'h6F_FFFF);
    check("tickcmd_sat0",   32'(sb),      32'h7F_FFFF);

    // Second tick mid-frame.
    run_frame(1'b1, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("ovr_pulses",  32'(n_over),   32'd1);
    check("ovr_svalid",  32'(n_svalid), 32'd1);
    check("ovr_latency", 32'(lat),      32'd12);
    check("ovr_sample",  32'(sa),       32'h0);

    // Fresh start, then a half-rate frame.
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    check("rst2_active", 32'(bus_a.o_active), 32'h0);
    repeat (2) @(negedge clk);
    send_cmd(1'b1, 7'd69, 16'h4000, drop);
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("pre_half_sample", 32'(sa), 32'h0);
    half_rate = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    half_rate = 1'b0;
    check("half_latency", 32'(lat),      32'd24);
    check("half_sample",  32'(sa),       32'h0F_FFFF);
    check("half_svalid",  32'(n_svalid), 32'd1);
    check("half_issues",  32'(n_issue),  32'd1);

    // Reset while draining, then normal frames.
    repeat (2) @(negedge clk);
    #2;
    bus_a.i_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    bus_a.i_tick = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("drain_rst_sample",    32'(bus_a.o_sample),       32'h0);
    check("drain_rst_active",    32'(bus_a.o_active),       32'h0);
    check("drain_rst_valid",     32'(bus_a.o_valid),        32'h0);
    check("drain_rst_svalid",    32'(bus_a.o_sample_valid), 32'h0);
    check("drain_rst_cmd_ready", 32'(bus_a.o_cmd_ready),    32'h0);
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(1'b1, 7'd69, 16'h4000, drop);
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("post_rst_sample0", 32'(sa), 32'h0);
    run_frame(1'b0, 1'b0, 1'b0, 7'd0, 16'h0, lat, sa, sb);
    check("post_rst_sample1", 32'(sa),  32'h0F_FFFF);
    check("post_rst_latency", 32'(lat), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
